adc_record_engine: RTL and testbench

Parametrised capture engine for the multi-channel ADC path. It takes deserialised frames already in the `adc_clkinp` domain and, after a trigger and an optional sample delay, writes a fixed-length record into the capture RAM. Decimation is done by summing each group of frames, and any channel can be bit-inverted. It sits between the LVDS deserialiser and the dual-port record RAM, and raises a completion interrupt for the HPS.

---
 rtl/adc_record_engine.sv | 183 ++++++++++++++++++
 tb/tb_adc_record_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_record_engine.sv
// Trigger-started, fixed-length ADC record capture with per-group decimation summing and per-channel inversion.
// Build option: define ADC_REC_SATURATE_EN to clamp each channel sum at 2^ACC_W-1 instead of wrapping.
module adc_record_engine #(
    parameter int NCH      = 8,
    parameter int SAMPLE_W = 12,
    parameter int ACC_W    = 16,
    parameter int ADDR_W   = 15,
    parameter int DIV_W    = 4,
    parameter int DLY_W    = 16
) (
    input  logic                      adc_clkinp,
    input  logic                      iStateReset_n,
    input  logic                      iSampleValid,
    input  logic [NCH*SAMPLE_W-1:0]   iSampleData,
    input  logic [NCH-1:0]            iInvertMask,
    input  logic                      itxTrig,
    input  logic                      iAbort,
    input  logic                      iIntClear,
    input  logic [ADDR_W:0]           iRecLength,
    input  logic [DIV_W-1:0]          iDecim,
    input  logic [DLY_W-1:0]          iTrigDelay,
    output logic                      otxTrigAck,
    output logic [7:0]                oRcvInterrupt,
    output logic                      oBusy,
    output logic                      oWREN,
    output logic [ADDR_W-1:0]         oWAddr,
    output logic [NCH*ACC_W-1:0]      oADCData,
    output logic [NCH*ACC_W/8-1:0]    oBYTEEN,
    output logic [7:0]                oMissedTrig
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DELAY   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DLY_W-1:0]  DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic                  r_trig_prev;
    logic [ADDR_W:0]       r_len;
    logic [DIV_W-1:0]      r_decim;
    logic [DIV_W-1:0]      r_grp;
    logic [DLY_W-1:0]      r_dly;
    logic [DLY_W-1:0]      r_dly_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_fin;
    logic [NCH*ACC_W-1:0]  r_acc;

    logic                  w_edge;
    logic                  w_cap;
    logic                  w_grp_end;
    logic                  w_last_word;
    logic [ADDR_W:0]       w_len_clamped;
    logic [NCH*ACC_W-1:0]  w_sum;

    function automatic logic [ACC_W-1:0] sample_ext(input logic [SAMPLE_W-1:0] s, input logic inv);
        sample_ext = ACC_W'(s ^ {SAMPLE_W{inv}});
    endfunction

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef ADC_REC_SATURATE_EN
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        acc_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        acc_add = a + b;
`endif
    endfunction

    assign w_edge        = itxTrig & ~r_trig_prev;
    assign w_len_clamped = (iRecLength > LEN_MAX) ? LEN_MAX : iRecLength;
    assign w_cap         = (r_state == S_CAPTURE) && iSampleValid && !r_fin;
    assign w_grp_end     = (r_grp == r_decim);
    assign w_last_word   = ({1'b0, r_addr} == (r_len - LEN_ONE));

    // First frame of a group replaces the running sum; later frames add into it.
    always_comb begin
        w_sum = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_grp == '0)
                w_sum[c*ACC_W +: ACC_W] = sample_ext(iSampleData[c*SAMPLE_W +: SAMPLE_W], iInvertMask[c]);
            else
                w_sum[c*ACC_W +: ACC_W] = acc_add(r_acc[c*ACC_W +: ACC_W],
                                                  sample_ext(iSampleData[c*SAMPLE_W +: SAMPLE_W], iInvertMask[c]));
        end
    end

    always_ff @(posedge adc_clkinp) begin
        if (w_cap)
            r_acc <= w_sum;
    end

    always_ff @(posedge adc_clkinp or negedge iStateReset_n) begin
        if (!iStateReset_n) begin
            r_state     <= S_IDLE;
            r_trig_prev <= 1'b0;
            r_len       <= '0;
            r_decim     <= '0;
            r_grp       <= '0;
            r_dly       <= '0;
            r_dly_cnt   <= '0;
            r_addr      <= '0;
            r_fin       <= 1'b0;
            oWREN       <= 1'b0;
            oWAddr      <= '0;
            oADCData    <= '0;
            oBYTEEN     <= '0;
            oMissedTrig <= '0;
        end else begin
            r_trig_prev <= itxTrig;
            oWREN       <= 1'b0;
            oBYTEEN     <= '0;
            if (w_edge && !iAbort && (r_state != S_IDLE) && (oMissedTrig != 8'hFF))
                oMissedTrig <= oMissedTrig + 8'd1;

            if (iAbort) begin
                r_state <= S_IDLE;
                r_fin   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_len     <= w_len_clamped;
                            r_decim   <= iDecim;
                            r_dly     <= iTrigDelay;
                            r_grp     <= '0;
                            r_dly_cnt <= '0;
                            r_addr    <= '0;
                            r_fin     <= 1'b0;
                            if (w_len_clamped == '0)
                                r_state <= S_DONE;
                            else if (iTrigDelay != '0)
                                r_state <= S_DELAY;
                            else
                                r_state <= S_CAPTURE;
                        end
                    end
                    S_DELAY: begin
                        // The strobe that completes the count is consumed here and never summed.
                        if (iSampleValid) begin
                            if (r_dly_cnt == (r_dly - DLY_ONE))
                                r_state <= S_CAPTURE;
                            else
                                r_dly_cnt <= r_dly_cnt + DLY_ONE;
                        end
                    end
                    S_CAPTURE: begin
                        if (r_fin) begin
                            r_state <= S_DONE;
                        end else if (iSampleValid) begin
                            if (w_grp_end) begin
                                oWREN    <= 1'b1;
                                oBYTEEN  <= '1;
                                oWAddr   <= r_addr;
                                oADCData <= w_sum;
                                r_addr   <= r_addr + ADDR_ONE;
                                r_grp    <= '0;
                                if (w_last_word)
                                    r_fin <= 1'b1;
                            end else begin
                                r_grp <= r_grp + DIV_ONE;
                            end
                        end
                    end
                    default: begin
                        if (iIntClear)
                            r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oBusy         = (r_state != S_IDLE);
    assign otxTrigAck    = (r_state == S_DELAY) || (r_state == S_CAPTURE);
    assign oRcvInterrupt = (r_state == S_DONE) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_adc_record_engine.sv
// Randomized and directed bench for adc_record_engine against a frame-queue reference model.
`timescale 1ns/1ps
module tb_adc_record_engine;
    localparam int NCH = 8, SAMPLE_W = 12, ACC_W = 16, ADDR_W = 15, DIV_W = 4, DLY_W = 16;
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     vld;
    logic [NCH*SAMPLE_W-1:0]  data;
    logic [NCH-1:0]           mask;
    logic                     trig, abort_i, clr;
    logic [ADDR_W:0]          len;
    logic [DIV_W-1:0]         decim;
    logic [DLY_W-1:0]         dly;
    logic                     ack, busy, wren;
    logic [7:0]               irq, missed;
    logic [ADDR_W-1:0]        waddr;
    logic [NCH*ACC_W-1:0]     wdata;
    logic [NCH*ACC_W/8-1:0]   be;

    logic [11:0] s_data;
    logic [0:0]  s_mask;
    logic [4:0]  s_len;
    logic [3:0]  s_decim, s_dly;
    logic        s_ack, s_busy, s_wren;
    logic [7:0]  s_irq, s_missed;
    logic [3:0]  s_waddr;
    logic [11:0] s_wdata;
    logic [0:0]  s_be;

    adc_record_engine #(.NCH(NCH), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
                        .DIV_W(DIV_W), .DLY_W(DLY_W)) u_dut (
        .adc_clkinp(clk), .iStateReset_n(rst_n), .iSampleValid(vld), .iSampleData(data),
        .iInvertMask(mask), .itxTrig(trig), .iAbort(abort_i), .iIntClear(clr),
        .iRecLength(len), .iDecim(decim), .iTrigDelay(dly), .otxTrigAck(ack),
        .oRcvInterrupt(irq), .oBusy(busy), .oWREN(wren), .oWAddr(waddr),
        .oADCData(wdata), .oBYTEEN(be), .oMissedTrig(missed));

    adc_record_engine #(.NCH(1), .SAMPLE_W(12), .ACC_W(12), .ADDR_W(4),
                        .DIV_W(4), .DLY_W(4)) u_small (
        .adc_clkinp(clk), .iStateReset_n(rst_n), .iSampleValid(vld), .iSampleData(s_data),
        .iInvertMask(s_mask), .itxTrig(trig), .iAbort(abort_i), .iIntClear(clr),
        .iRecLength(s_len), .iDecim(s_decim), .iTrigDelay(s_dly), .otxTrigAck(s_ack),
        .oRcvInterrupt(s_irq), .oBusy(s_busy), .oWREN(s_wren), .oWAddr(s_waddr),
        .oADCData(s_wdata), .oBYTEEN(s_be), .oMissedTrig(s_missed));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [NCH*SAMPLE_W-1:0] frames[$];
    logic [ADDR_W-1:0]       wa_q[$];
    logic [NCH*ACC_W-1:0]    wd_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic t, input logic v, input logic a, input logic c);
        trig = t; vld = v; abort_i = a; clr = c;
        data = rand_frame();
        tick();
    endtask

    function automatic logic [NCH*SAMPLE_W-1:0] rand_frame();
        logic [NCH*SAMPLE_W-1:0] f;
        for (int c = 0; c < NCH; c++) f[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
        return f;
    endfunction

    // Sum of non-negative terms: clamping or wrapping the total equals doing it per add.
    function automatic longint fold(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
`ifdef ADC_REC_SATURATE_EN
        return (v > lim) ? lim : v;
`else
        return v & lim;
`endif
    endfunction

    function automatic logic [NCH*ACC_W-1:0] model_word(input int w, input int dl, input int dc,
                                                        input logic [NCH-1:0] m);
        logic [NCH*ACC_W-1:0] r;
        logic [NCH*SAMPLE_W-1:0] f;
        longint sum, s;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            sum = 0;
            for (int k = 0; k <= dc; k++) begin
                f = frames[dl + w*(dc+1) + k];
                s = longint'(f[c*SAMPLE_W +: SAMPLE_W]);
                if (m[c]) s = (longint'(1) << SAMPLE_W) - 1 - s;
                sum += s;
            end
            r[c*ACC_W +: ACC_W] = ACC_W'(fold(sum, ACC_W));
        end
        return r;
    endfunction

    // mode 0: random frames with gaps; 1: ch0 = cycle index every cycle; 2: all ones every cycle
    task automatic run_record(input int l, input int dc, input int dl, input logic [NCH-1:0] m, input int mode);
        int cyc, last_wr, int_at;
        frames.delete(); wa_q.delete(); wd_q.delete();
        cyc = 0; last_wr = -1; int_at = -1;
        trig = 0; vld = 0; tick();
        while (cyc < BUDGET && int_at < 0) begin
            trig = 1; mask = m;
            if (cyc == 0) begin
                len = (ADDR_W+1)'(l); decim = DIV_W'(dc); dly = DLY_W'(dl);
            end else begin
                len = (ADDR_W+1)'($urandom); decim = DIV_W'($urandom); dly = DLY_W'($urandom);
            end
            case (mode)
                0: begin vld = ($urandom_range(3) != 0); data = rand_frame(); end
                1: begin vld = 1; data = '0; data[SAMPLE_W-1:0] = SAMPLE_W'(cyc); end
                default: begin vld = 1; data = '1; end
            endcase
            if (vld && cyc >= 1) frames.push_back(data);
            tick();
            if (cyc == 0) begin
                check("ack_after_trig", ack, (l != 0));
                check("busy_after_trig", busy, 1);
            end
            if (wren) begin
                wa_q.push_back(waddr); wd_q.push_back(wdata); last_wr = cyc;
                check("byteen", be, {(NCH*ACC_W/8){1'b1}});
            end
            if (irq == 8'hFF) int_at = cyc;
            cyc++;
        end
        vld = 0; trig = 0;
        check("irq_seen", (int_at >= 0), 1);
        check("n_words", wa_q.size(), l);
        if (frames.size() >= dl + l*(dc+1)) begin
            for (int w = 0; w < l && w < wa_q.size(); w++) begin
                check($sformatf("addr%0d", w), wa_q[w], w);
                check($sformatf("data%0d", w), wd_q[w], model_word(w, dl, dc, m));
            end
        end else begin
            check("frames_short", frames.size(), dl + l*(dc+1));
        end
        if (l > 0) check("irq_latency", int_at - last_wr, 1);
        else       check("irq_len0", int_at, 0);
        tick();
        check("irq_hold", irq, 8'hFF);
        check("ack_done", ack, 0);
        clr = 1; tick(); clr = 0;
        check("irq_cleared", irq, 8'h00);
        check("idle_after_clr", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw, l, dc, dl;
        logic [11:0] exp12;
        rst_n = 0; vld = 0; data = '0; mask = '0; trig = 0; abort_i = 0; clr = 0;
        len = '0; decim = '0; dly = '0;
        s_data = '0; s_mask = '0; s_len = '0; s_decim = '0; s_dly = '0;
        tick(); tick();
        check("rst_ack", ack, 0);   check("rst_irq", irq, 0);    check("rst_busy", busy, 0);
        check("rst_wren", wren, 0); check("rst_waddr", waddr, 0); check("rst_data", wdata, 0);
        check("rst_be", be, 0);     check("rst_missed", missed, 0);
        #2 rst_n = 1;
        tick();

        run_record(4, 0, 0, '0, 1);
        for (int i = 0; i < 4 && i < wd_q.size(); i++)
            check($sformatf("seq_ch0_%0d", i), wd_q[i][ACC_W-1:0], i + 1);
        run_record(2, 3, 0, '0, 2);
        for (int i = 0; i < 2 && i < wd_q.size(); i++) check("sum4_ch0", wd_q[i][ACC_W-1:0], 16'h3FFC);
        run_record(2, 3, 0, 8'h01, 2);
        for (int i = 0; i < 2 && i < wd_q.size(); i++) begin
            check("sum4_inv_ch0", wd_q[i][ACC_W-1:0], 0);
            check("sum4_inv_ch1", wd_q[i][2*ACC_W-1:ACC_W], 16'h3FFC);
        end
        // Trigger-cycle frame is the first; five delay strobes follow, so cycle 6 (seventh frame) is kept.
        run_record(1, 0, 5, '0, 1);
        if (wd_q.size() == 1) check("delay5_ch0", wd_q[0][ACC_W-1:0], 6);
        run_record(0, 0, 0, '0, 0);
        for (int r = 0; r < 10; r++) begin
            l = $urandom_range(1, 6); dc = $urandom_range(0, 3); dl = $urandom_range(0, 4);
            run_record(l, dc, dl, NCH'($urandom), 0);
        end

        // Narrow-accumulator instance: two full-scale frames per word, then the length clamp.
        len = '0; s_len = 5'd1; s_decim = 4'd1; s_dly = 4'd0; s_data = 12'hFFF; s_mask = 1'b0;
        step(0, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        exp12 = 12'(fold(2 * 4095, 12));
        check("sat_wren", s_wren, 1);
        check("sat_data", s_wdata, exp12);
        step(1, 0, 0, 0);
        check("sat_irq", s_irq, 8'hFF);
        step(0, 0, 0, 1);
        s_len = 5'd31; s_decim = 4'd0;
        step(0, 0, 0, 0); step(1, 1, 0, 0);
        nw = 0;
        for (int i = 0; i < 60 && s_irq != 8'hFF; i++) begin
            step(1, 1, 0, 0);
            if (s_wren) nw++;
        end
        check("clamp_words", nw, 16);
        check("clamp_irq", s_irq, 8'hFF);
        check("clamp_last_addr", s_waddr, 15);
        step(0, 0, 0, 1);
        check("clamp_idle", s_busy, 0);

        // Missed triggers: one in capture, two in done (second with clear), abort edge in idle not counted.
        len = 4; decim = 3; dly = 0;
        step(0, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(0, 1, 0, 0); step(1, 1, 0, 0);
        check("missed_capture", missed, 1);
        for (int i = 0; i < 40 && irq != 8'hFF; i++) step(1, 1, 0, 0);
        check("missed_rec_done", irq, 8'hFF);
        step(0, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(1, 0, 0, 1);
        check("missed_three", missed, 3);
        check("clr_with_edge_idle", busy, 0);
        step(0, 0, 0, 0); step(1, 0, 1, 0);
        check("abort_edge_idle", busy, 0);
        check("abort_edge_uncounted", missed, 3);

        // Abort mid-record.
        len = 8; decim = 0;
        step(0, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        check("pre_abort_wren", wren, 1);
        step(1, 1, 1, 0);
        check("abort_wren", wren, 0); check("abort_busy", busy, 0);
        check("abort_ack", ack, 0);   check("abort_irq", irq, 0);
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0);
            if (wren || irq != 0) nw++;
        end
        check("abort_quiet", nw, 0);

        // Asynchronous reset in the middle of a write pulse.
        step(0, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        check("pre_reset_wren", wren, 1);
        #2 rst_n = 0;
        #1;
        check("areset_wren", wren, 0);   check("areset_busy", busy, 0);
        check("areset_ack", ack, 0);     check("areset_waddr", waddr, 0);
        check("areset_data", wdata, 0);  check("areset_be", be, 0);
        check("areset_missed", missed, 0); check("areset_irq", irq, 0);
        trig = 0; vld = 0;
        #3 rst_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
